// File: rtl/div_ctrl_if.sv
// Handshake bundle between the E stage and the multi-cycle divider.
// The E stage is the master; div_ctrl is the slave.
interface div_ctrl_if;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic        hilowrite;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, signed_div, a, b, flush,
        input  stall, busy, done, hilowrite, hi, lo
    );

    modport slave (
        input  start, signed_div, a, b, flush,
        output stall, busy, done, hilowrite, hi, lo
    );
endinterface

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: 32-step restoring divider with sign fix-up,
// E-stage stall and a one-cycle HI/LO write strobe.
module div_ctrl (
    input  logic       clk,
    input  logic       resetn,
    div_ctrl_if.slave  dif
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state;
    logic        sdiv;
    logic        sa;
    logic        sb;
    logic [31:0] dvsr;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [4:0]  cnt;
    logic        done_q;
    logic        accept;
    logic [32:0] diff;
    logic        neg_q;
    logic        neg_r;

    // 0x80000000 maps to itself and is then read as unsigned
    function automatic logic [31:0] mag(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    assign accept = dif.start & ~dif.flush;

    // rem < dvsr before each shift, so diff[32] is exactly the borrow
    assign diff = {rem, quo[31]} - {1'b0, dvsr};

    assign neg_q = sdiv & (sa ^ sb);
    assign neg_r = sdiv & sa;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            sdiv   <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dvsr   <= '0;
            rem    <= '0;
            quo    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sdiv  <= dif.signed_div;
                        sa    <= dif.a[31];
                        sb    <= dif.b[31];
                        quo   <= dif.signed_div ? mag(dif.a) : dif.a;
                        dvsr  <= dif.signed_div ? mag(dif.b) : dif.b;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (dif.flush) begin
                        state <= IDLE;
                    end else begin
                        rem <= diff[32] ? {rem[30:0], quo[31]}
                                        : diff[31:0];
                        quo <= {quo[30:0], ~diff[32]};
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) state <= FIX;
                    end
                end
                FIX: begin
                    if (dif.flush) begin
                        state <= IDLE;
                    end else begin
                        lo_q   <= neg_q ? (~quo + 32'd1) : quo;
                        hi_q   <= neg_r ? (~rem + 32'd1) : rem;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dif.busy      = (state != IDLE);
    assign dif.stall     = ((state == IDLE) & accept)
                         | (state == RUN)
                         | (state == FIX);
    assign dif.done      = done_q;
    assign dif.hilowrite = done_q;
    assign dif.hi        = hi_q;
    assign dif.lo        = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomized checks of div_ctrl against an arithmetic
// model of DIV/DIVU including divide-by-zero and overflow cases.
module tb_div_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   passed = 0;
    int   fails = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    div_ctrl_if dif ();

    div_ctrl u_dut (
        .clk    (clk),
        .resetn (resetn),
        .dif    (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit sd, input logic [31:0] x,
                                  input logic [31:0] y,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
        int sx;
        int sy;
        sx = x;
        sy = y;
        if (!sd) begin
            if (y == 0) begin
                q = 32'hFFFFFFFF;
                r = x;
            end else begin
                q = x / y;
                r = x % y;
            end
        end else if (y == 0) begin
            q = x[31] ? 32'd1 : 32'hFFFFFFFF;
            r = x;
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
        end else begin
            q = sx / sy;
            r = sx % sy;
        end
    endfunction

    // Called at posedge+1 of the start cycle; returns at posedge+1
    // of the first IDLE cycle after DONE.
    task automatic do_div(input bit sd, input logic [31:0] av,
                          input logic [31:0] bv, input bit scr,
                          input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        model(sd, av, bv, eq, er);
        dif.start      = 1'b1;
        dif.flush      = 1'b0;
        dif.signed_div = sd;
        dif.a          = av;
        dif.b          = bv;
        @(negedge clk);
        chk({tag, "_stall_t"}, dif.stall, 1);
        @(posedge clk); #1;
        dif.start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (scr) begin
                dif.a          = $urandom;
                dif.b          = $urandom;
                dif.signed_div = 1'($urandom);
                dif.start      = 1'($urandom);
            end
            @(negedge clk);
            chk({tag, "_run"},
                {dif.stall, dif.busy, dif.done, dif.hilowrite},
                4'b1100);
            @(posedge clk); #1;
        end
        dif.start = 1'b0;
        @(negedge clk);
        chk({tag, "_done"},
            {dif.stall, dif.busy, dif.done, dif.hilowrite}, 4'b0111);
        chk({tag, "_lo"}, dif.lo, eq);
        chk({tag, "_hi"}, dif.hi, er);
        last_q = eq;
        last_r = er;
        @(posedge clk); #1;
        chk({tag, "_idle"},
            {dif.stall, dif.busy, dif.done, dif.hilowrite}, 4'b0000);
    endtask

    initial begin
        bit seen;
        dif.start      = 1'b0;
        dif.flush      = 1'b0;
        dif.signed_div = 1'b0;
        dif.a          = '0;
        dif.b          = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags",
            {dif.stall, dif.busy, dif.done, dif.hilowrite}, 4'b0000);
        chk("rst_hilo", {dif.hi, dif.lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        do_div(1'b0, 32'd100, 32'd7, 1'b0, "divu_100_7");
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, "div_m7_2");
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, "div_7_m2");
        do_div(1'b0, 32'd5, 32'd0, 1'b0, "divu_by0");
        do_div(1'b1, 32'hFFFFFF9C, 32'd0, 1'b0, "div_neg_by0");
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
        do_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, "divu_max_1");

        // flush in RUN at count 10
        dif.start      = 1'b1;
        dif.signed_div = 1'b0;
        dif.a          = 32'd1000;
        dif.b          = 32'd3;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        dif.flush = 1'b1;
        @(negedge clk);
        chk("flush_run_stall", dif.stall, 1);
        @(posedge clk); #1;
        dif.flush = 1'b0;
        chk("flush_idle",
            {dif.stall, dif.busy, dif.done, dif.hilowrite}, 4'b0000);
        chk("flush_hold", {dif.hi, dif.lo}, {last_r, last_q});
        @(posedge clk); #1;
        chk("flush_nodone", dif.done, 0);
        do_div(1'b0, 32'd1000, 32'd3, 1'b0, "after_flush");

        // start and flush together are not accepted
        dif.start = 1'b1;
        dif.flush = 1'b1;
        dif.a     = 32'd9;
        dif.b     = 32'd2;
        @(negedge clk);
        chk("sf_stall", dif.stall, 0);
        @(posedge clk); #1;
        dif.start = 1'b0;
        dif.flush = 1'b0;
        chk("sf_busy", dif.busy, 0);
        seen = 1'b0;
        repeat (36) begin
            @(negedge clk);
            if (dif.done || dif.busy) seen = 1'b1;
        end
        chk("sf_no_activity", seen, 0);
        @(posedge clk); #1;

        // asynchronous reset during FIX
        dif.start      = 1'b1;
        dif.signed_div = 1'b1;
        dif.a          = 32'hFFFFFF9C;
        dif.b          = 32'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        chk("fix_busy", {dif.stall, dif.busy, dif.done}, 3'b110);
        resetn = 1'b0;
        #1;
        chk("arst_flags",
            {dif.stall, dif.busy, dif.done, dif.hilowrite}, 4'b0000);
        chk("arst_hilo", {dif.hi, dif.lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("arst_nowrite", {dif.done, dif.hilowrite}, 2'b00);
        do_div(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0, "after_rst");

        // back to back with operand noise during RUN
        do_div(1'b0, 32'd123456789, 32'd1000, 1'b1, "b2b_a");
        do_div(1'b1, 32'hF0000001, 32'd77, 1'b1, "b2b_b");

        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            if (i % 4 == 0)
                rb = 32'd0;
            else if ($urandom_range(0, 1) == 1)
                rb = $urandom;
            else
                rb = $urandom_range(1, 300);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            do_div(1'($urandom), ra, rb, 1'b1, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the multi-cycle DIV/DIVU path in the execute stage. It accepts a decoded divide request, runs a 32-iteration restoring divider and stalls the pipeline while the divider is busy. On completion it presents the quotient and remainder to the HI/LO register file with a one-cycle write strobe. An exception flush aborts an in-flight divide without writing HI/LO.

## Interface

Parameters:
- none; the datapath is fixed at 32 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  divide request from the E stage; only meaningful in IDLE
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- a  in  32  dividend (rs); sampled on the accepted start
- b  in  32  divisor (rt); sampled on the accepted start
- flush  in  1  exception/eret flush of the E stage; aborts the divide
- stall  out  1  pipeline stall request
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse; hi/lo are valid in this cycle
- hilowrite  out  1  equal to done; write enable toward HI/LO
- hi  out  32  remainder (registered)
- lo  out  32  quotient (registered)

## Operation

- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 and flush=0 is an accepted start.
  - Latch signed_div and the operand signs.
  - Latch |a| and |b| when signed_div=1; otherwise latch raw a and b.
  - Clear the partial remainder and count. Next state is RUN.
- RUN: one restoring step per cycle.
  - Shift {rem, quo} left by 1 and trial-subtract |b| from rem (33-bit subtract).
  - If there is no borrow, keep the difference and set the quotient LSB to 1.
  - count increments 0..31; at count=31, next state is FIX.
- FIX (signed only; a pass-through for unsigned):
  - Negate the quotient when sign(a) != sign(b).
  - Negate the remainder when sign(a)=1.
  - Register the results into hi/lo. Next state is DONE.
- DONE: done=hilowrite=1 for exactly one cycle. Next state is IDLE.
- Arithmetic rules:
  - |x| of 0x80000000 is 0x80000000, treated as unsigned.
  - All negation is two's complement, modulo 2^32.
- Divide by zero has no special path. The restoring algorithm gives quotient 0xFFFFFFFF and remainder |a|, then FIX applies the sign rules:
  - DIVU: lo=0xFFFFFFFF, hi=a.
  - DIV with a<0: lo=0x00000001, hi=a.
- DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Operand changes after acceptance are ignored.
- start while busy is ignored; no queueing.
- flush:
  - In any non-IDLE state, the next state is IDLE; done, hilowrite and hi/lo are not updated.
  - A flush during DONE does not suppress the done pulse, because HI/LO commit is in that cycle.
  - Simultaneous start and flush in IDLE: flush wins and the start is not accepted.
- hi/lo hold their last value until the next FIX.

## Timing

- Reset values: state=IDLE; stall=0, busy=0, done=0, hilowrite=0, hi=0, lo=0; internal counters and registers cleared.
- Reset is asynchronous: asserting resetn=0 mid-operation forces IDLE immediately, with no write.
- stall = (IDLE & start & ~flush) | RUN | FIX.
  - The combinational term holds the instruction in E from the request cycle.
  - stall is low in DONE, so the divide instruction advances in that same cycle.
- Latency from an accepted start in cycle t:
  - RUN occupies cycles t+1..t+32.
  - FIX occupies cycle t+33.
  - done is high in cycle t+34.
- stall is high in cycles t..t+33 (34 cycles).
- Back-to-back divides: a start in cycle t+35 (first IDLE after DONE) is accepted. Two divides complete with no gap beyond that one IDLE cycle.
- done never asserts without a preceding accepted start and an uninterrupted RUN+FIX sequence.

## Test plan

- DIVU a=100, b=7, start at t: stall high t..t+33; done=hilowrite=1 only at t+34; lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIV a=7, b=0xFFFFFFFE: lo=0xFFFFFFFD, hi=1.
- Boundary operands:
  - DIVU a=5, b=0: lo=0xFFFFFFFF, hi=5.
  - DIV a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU a=0xFFFFFFFF, b=1: lo=0xFFFFFFFF, hi=0.
- flush at RUN count=10: IDLE next cycle; busy=0; no done; hi/lo keep the prior values. A start two cycles later runs normally with full latency. Also: start with flush in the same IDLE cycle, not accepted, stall=0.
- resetn pulsed low in the FIX cycle: all outputs 0 immediately; no hilowrite; a following start works.
- Two divides back to back (second start at t+35) with changing operands on a/b during RUN: both results correct, and the operand changes are ignored.
